ps2_bbc_keyboard: RTL and testbench
===================================

# ps2_bbc_keyboard

Converts a PS/2 keyboard byte stream into the BBC Micro key-down matrix consumed by `bbc_micro_keyboard`. It sits directly upstream of that block and drives its `bbc_keyboard__*` inputs. It receives and checks PS/2 frames, tracks extended (E0) and release (F0) prefixes, and maps each scan code to a column/row bit. It also maintains a registered 80-bit key-down matrix plus the Break (reset) key.

## Interface
- `timeout_cycles`, default 8192: clk cycles without a PS/2 falling edge before a partial frame is abandoned.
- `dip_switches`, default 8'h00: static DIP value driven onto row 0 of columns 2..9. Column c row 0 = `dip_switches[9-c]`; 1 = switch closed.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `bbc_keyboard__reset_pressed` out 1: Break key held.
- `bbc_keyboard__keys_down_cols_0_to_7` out 64: bit c*8+r = column c, row r pressed.
- `bbc_keyboard__keys_down_cols_8_to_9` out 16: bit (c-8)*8+r = column c, row r pressed.
- `rx_error` out 1: one-cycle pulse when a frame fails parity or stop-bit check, or times out.

## Operation
- **Synchroniser:** 2-flop synchroniser on each of `ps2_clk` and `ps2_data`, plus a registered previous `ps2_clk`. A falling edge is detected when previous = 1 and current = 0.
- **Receiver FSM (IDLE → DATA → PARITY → STOP → IDLE):**
  - Sampling happens on detected falling edges only.
  - IDLE: start bit must be 0. A 1 is ignored and the FSM stays in IDLE.
  - DATA: 8 bits, LSB first, tracked by a 3-bit counter.
  - PARITY: parity must be odd over data plus parity bit.
  - STOP: stop bit must be 1. A good frame pulses `byte_valid` for 1 cycle. A bad frame pulses `rx_error` and the byte is discarded.
- **Timeout:** outside IDLE, a counter reloads on every edge. Reaching `timeout_cycles` pulses `rx_error` and forces IDLE. The counter saturates and never wraps.
- **Decoder FSM (NORMAL, EXT, REL, EXT_REL), one step per `byte_valid`:**
  - E0: NORMAL→EXT.
  - F0: NORMAL→REL, EXT→EXT_REL.
  - Any other byte is a key code with extended = (state is EXT or EXT_REL) and release = (state is REL or EXT_REL). The FSM then returns to NORMAL.
  - In NORMAL only, AA (BAT pass), 00 and FF (overrun) clear the whole matrix and `reset_pressed`.
  - E1, FA, FE and EE in NORMAL are ignored.
- **Mapping:** {extended, code} maps to {valid, is_break, column[3:0], row[2:0]}.
  - Unmapped codes are ignored, but their prefix state is still consumed.
  - Press sets the bit; release clears it.
  - Keys that alias the same bit (both Shifts → c0r0; both Ctrls → c1r0) share it, so releasing either clears it.
  - F12 (07) is Break: it drives `reset_pressed` and does not touch the matrix.
- **Row 0:** bits for columns 2..9 always reflect `dip_switches` and are not writable by scan codes. They are forced even across AA/00/FF clears.
- **Reset:** all outputs are registered.
  - Matrix = 0 except the DIP bits.
  - `reset_pressed` = 0, `rx_error` = 0.
  - Both FSMs in idle/NORMAL; counters = 0.
  - Reset mid-frame discards the partial frame.

## Timing
- A raw `ps2_clk` fall is detected on the 3rd rising `clk` edge after the fall, given the 2 sync flops and the edge register.
- `byte_valid` is asserted the cycle after the stop-bit edge is detected.
- The matrix bit, `reset_pressed` or the clear takes effect in the cycle after `byte_valid`. Outputs change 1 cycle after `byte_valid`.
- `rx_error` is registered and high for exactly 1 cycle per error.
- Back-to-back bytes need no gap. The decoder accepts one byte per cycle.

## Structure
- **Package `ps2_bbc_keyboard_types`:**
  - decoder state enum;
  - key-map entry struct {valid, is_break, column, row};
  - mapping function or constant table for all BBC keys. Examples:
    - 1C→c1r4 'A'
    - 76→c0r7 Esc
    - 5A→c9r4 Return
    - E0 74→c9r7 Right
    - 12/59→c0r0 Shift
    - 14/E0 14→c1r0 Ctrl
    - 07→Break
  - the special-byte constants E0, F0, AA.
- **Sub-module `ps2_receiver`:** synchroniser, receiver FSM and timeout. Outputs `byte_valid`, `byte_data[7:0]` and `rx_error`.

## Test plan
- Reset, then frame 1C → bit 12 of `cols_0_to_7` = 1. Then F0 1C → bit 12 = 0. No `rx_error`.
- E0 74 → `cols_8_to_9[15]` = 1. E0 F0 74 → cleared. Plain 74 (keypad 6 → c4r3) sets bit 35, not bit 15.
- Frame with bad parity for 76 → `rx_error` pulses once and bit 7 stays 0. A following good 76 sets bit 7.
- Start 1C, stop after 5 data bits for `timeout_cycles` → `rx_error`, receiver returns to IDLE. A following good frame decodes correctly.
- 07 → `reset_pressed` = 1. F0 07 → 0.
- With 1C and 12 held, AA → all non-DIP bits 0. With `dip_switches`=8'h81, bits 16 and 8 of `cols_8_to_9`... precisely `cols_0_to_7[16]` (c2r0) = 1 and `cols_8_to_9[8]` (c9r0) = 1 at all times, including after reset and after AA.

Source files
------------

// File: rtl/ps2_bbc_keyboard_pkg.sv
// Shared types for the PS/2 to BBC Micro keyboard bridge: decoder states,
// key-map entries, prefix/special scan-code constants and the scan-code map.
package ps2_bbc_keyboard_types;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_EXT,
        DEC_REL,
        DEC_EXT_REL
    } dec_state_t;

    typedef struct packed {
        logic       valid;
        logic       is_break;
        logic [3:0] column;
        logic [2:0] row;
    } key_map_t;

    localparam logic [7:0] CODE_EXT      = 8'hE0;
    localparam logic [7:0] CODE_REL      = 8'hF0;
    localparam logic [7:0] CODE_BAT      = 8'hAA;
    localparam logic [7:0] CODE_ZERO     = 8'h00;
    localparam logic [7:0] CODE_OVERRUN  = 8'hFF;
    localparam logic [7:0] CODE_PAUSE    = 8'hE1;
    localparam logic [7:0] CODE_ACK      = 8'hFA;
    localparam logic [7:0] CODE_RESEND   = 8'hFE;
    localparam logic [7:0] CODE_ECHO     = 8'hEE;

    function automatic key_map_t mk(input int col, input int row);
        mk = '{valid: 1'b1, is_break: 1'b0, column: 4'(col), row: 3'(row)};
    endfunction

    // Row 0 of columns 2..9 carries the DIP switches; column c uses dip[9-c].
    function automatic logic [79:0] dip_matrix(input logic [7:0] dip);
        dip_matrix = '0;
        for (int c = 2; c <= 9; c++) dip_matrix[c*8] = dip[9-c];
    endfunction

    // {extended, set-2 code} -> BBC column/row. PC F10 is f0, F11/End are Copy.
    function automatic key_map_t map_key(input logic extended, input logic [7:0] code);
        map_key = '0;
        case ({extended, code})
            9'h012, 9'h059:                 map_key = mk(0, 0);
            9'h014, 9'h114:                 map_key = mk(1, 0);
            9'h007:                         map_key = '{valid: 1'b1, is_break: 1'b1, column: 4'd0, row: 3'd0};
            9'h015:                         map_key = mk(0, 1);
            9'h026, 9'h07A:                 map_key = mk(1, 1);
            9'h025, 9'h06B:                 map_key = mk(2, 1);
            9'h02E, 9'h073:                 map_key = mk(3, 1);
            9'h00C:                         map_key = mk(4, 1);
            9'h03E, 9'h075:                 map_key = mk(5, 1);
            9'h083:                         map_key = mk(6, 1);
            9'h04E:                         map_key = mk(7, 1);
            9'h055:                         map_key = mk(8, 1);
            9'h16B:                         map_key = mk(9, 1);
            9'h009:                         map_key = mk(0, 2);
            9'h01D:                         map_key = mk(1, 2);
            9'h024:                         map_key = mk(2, 2);
            9'h02C:                         map_key = mk(3, 2);
            9'h03D, 9'h06C:                 map_key = mk(4, 2);
            9'h043:                         map_key = mk(5, 2);
            9'h046, 9'h07D:                 map_key = mk(6, 2);
            9'h045, 9'h070:                 map_key = mk(7, 2);
            9'h00E:                         map_key = mk(8, 2);
            9'h172:                         map_key = mk(9, 2);
            9'h016, 9'h069:                 map_key = mk(0, 3);
            9'h01E, 9'h072:                 map_key = mk(1, 3);
            9'h023:                         map_key = mk(2, 3);
            9'h02D:                         map_key = mk(3, 3);
            9'h036, 9'h074:                 map_key = mk(4, 3);
            9'h03C:                         map_key = mk(5, 3);
            9'h044:                         map_key = mk(6, 3);
            9'h04D:                         map_key = mk(7, 3);
            9'h054:                         map_key = mk(8, 3);
            9'h175:                         map_key = mk(9, 3);
            9'h058:                         map_key = mk(0, 4);
            9'h01C:                         map_key = mk(1, 4);
            9'h022:                         map_key = mk(2, 4);
            9'h02B:                         map_key = mk(3, 4);
            9'h035:                         map_key = mk(4, 4);
            9'h03B:                         map_key = mk(5, 4);
            9'h042:                         map_key = mk(6, 4);
            9'h052:                         map_key = mk(8, 4);
            9'h05A, 9'h15A:                 map_key = mk(9, 4);
            9'h011:                         map_key = mk(0, 5);
            9'h01B:                         map_key = mk(1, 5);
            9'h021:                         map_key = mk(2, 5);
            9'h034:                         map_key = mk(3, 5);
            9'h033:                         map_key = mk(4, 5);
            9'h031:                         map_key = mk(5, 5);
            9'h04B:                         map_key = mk(6, 5);
            9'h04C:                         map_key = mk(7, 5);
            9'h05B:                         map_key = mk(8, 5);
            9'h066, 9'h171:                 map_key = mk(9, 5);
            9'h00D:                         map_key = mk(0, 6);
            9'h01A:                         map_key = mk(1, 6);
            9'h029:                         map_key = mk(2, 6);
            9'h02A:                         map_key = mk(3, 6);
            9'h032:                         map_key = mk(4, 6);
            9'h03A:                         map_key = mk(5, 6);
            9'h041:                         map_key = mk(6, 6);
            9'h049:                         map_key = mk(7, 6);
            9'h04A:                         map_key = mk(8, 6);
            9'h078, 9'h169:                 map_key = mk(9, 6);
            9'h076:                         map_key = mk(0, 7);
            9'h005:                         map_key = mk(1, 7);
            9'h006:                         map_key = mk(2, 7);
            9'h004:                         map_key = mk(3, 7);
            9'h003:                         map_key = mk(4, 7);
            9'h00B:                         map_key = mk(5, 7);
            9'h00A:                         map_key = mk(6, 7);
            9'h001:                         map_key = mk(7, 7);
            9'h05D:                         map_key = mk(8, 7);
            9'h174:                         map_key = mk(9, 7);
            default:                        map_key = '0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_bbc_keyboard_receiver.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge
// sampling FSM with odd-parity/stop checks, and an inter-edge timeout.
module ps2_receiver #(
    parameter int timeout_cycles = 8192
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       rx_error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int             TW         = $clog2(timeout_cycles + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(timeout_cycles - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_ok;
    logic [TW-1:0] timer;

    assign fall = clk_prev & ~clk_sync[1];

    // NOTE: every register here is written with <= so all updates see the
    // pre-edge values; mixing in = would make the result order-dependent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_ok  <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            rx_error   <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            rx_error   <= 1'b0;

            // Idle link or fresh edge keeps the watchdog at zero; it stops at the limit.
            if (state == ST_IDLE || fall) begin
                timer <= '0;
            end else if (timer >= TIMER_LAST) begin
                timer    <= '0;
                rx_error <= 1'b1;
                state    <= ST_IDLE;
            end else begin
                timer <= timer + 1'b1;
            end

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_sync[1]) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {data_sync[1], shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        parity_ok <= ^{shift_reg, data_sync[1]};
                        state     <= ST_STOP;
                    end
                    default: begin
                        if (data_sync[1] && parity_ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift_reg;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_bbc_keyboard.sv
// PS/2 keyboard to BBC Micro key-down matrix: prefix decoding, scan-code
// mapping, Break tracking and DIP switches forced into row 0.
module ps2_bbc_keyboard
    import ps2_bbc_keyboard_types::*;
#(
    parameter int         timeout_cycles = 8192,
    parameter logic [7:0] dip_switches   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        bbc_keyboard__reset_pressed,
    output logic [63:0] bbc_keyboard__keys_down_cols_0_to_7,
    output logic [15:0] bbc_keyboard__keys_down_cols_8_to_9,
    output logic        rx_error
);

    localparam logic [79:0] DIP_MASK = dip_matrix(8'hFF);
    localparam logic [79:0] DIP_BITS = dip_matrix(dip_switches);

    logic        byte_valid;
    logic [7:0]  byte_data;
    dec_state_t  dec_state;
    dec_state_t  dec_next;
    key_map_t    entry;
    logic        extended;
    logic        key_release;
    logic        clear_all;
    logic        key_event;
    logic [6:0]  key_idx;
    logic [79:0] keys_q;
    logic [79:0] keys_next;
    logic        reset_next;

    ps2_receiver #(.timeout_cycles(timeout_cycles)) u_receiver (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .rx_error   (rx_error)
    );

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        extended    = (dec_state == DEC_EXT) || (dec_state == DEC_EXT_REL);
        key_release = (dec_state == DEC_REL) || (dec_state == DEC_EXT_REL);
        entry       = map_key(extended, byte_data);
        key_idx     = {entry.column, entry.row};
        dec_next    = dec_state;
        clear_all   = 1'b0;
        key_event   = 1'b0;

        if (byte_valid) begin
            dec_next = DEC_NORMAL;
            if (dec_state == DEC_NORMAL && byte_data == CODE_EXT) begin
                dec_next = DEC_EXT;
            end else if (byte_data == CODE_REL && dec_state == DEC_NORMAL) begin
                dec_next = DEC_REL;
            end else if (byte_data == CODE_REL && dec_state == DEC_EXT) begin
                dec_next = DEC_EXT_REL;
            end else if (dec_state == DEC_NORMAL &&
                         byte_data inside {CODE_BAT, CODE_ZERO, CODE_OVERRUN}) begin
                clear_all = 1'b1;
            end else if (!(dec_state == DEC_NORMAL &&
                           byte_data inside {CODE_PAUSE, CODE_ACK, CODE_RESEND, CODE_ECHO})) begin
                key_event = entry.valid;
            end
        end

        keys_next  = keys_q;
        reset_next = bbc_keyboard__reset_pressed;
        if (clear_all) begin
            keys_next  = '0;
            reset_next = 1'b0;
        end else if (key_event && entry.is_break) begin
            reset_next = !key_release;
        end else if (key_event) begin
            keys_next[key_idx] = !key_release;
        end
        keys_next = (keys_next & ~DIP_MASK) | DIP_BITS;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_state                   <= DEC_NORMAL;
            keys_q                      <= DIP_BITS;
            bbc_keyboard__reset_pressed <= 1'b0;
        end else begin
            dec_state                   <= dec_next;
            keys_q                      <= keys_next;
            bbc_keyboard__reset_pressed <= reset_next;
        end
    end

    assign bbc_keyboard__keys_down_cols_0_to_7 = keys_q[63:0];
    assign bbc_keyboard__keys_down_cols_8_to_9 = keys_q[79:64];

endmodule

// File: tb/tb_ps2_bbc_keyboard.sv
// Scoreboard bench for ps2_bbc_keyboard: directed PS/2 frames push expected
// matrix/Break/error snapshots; a monitor compares on every output event.
module tb_ps2_bbc_keyboard;

    localparam int          TIMEOUT   = 200;
    localparam logic [79:0] DIP_MODEL = (80'd1 << 16) | (80'd1 << 72);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        reset_pressed;
    logic [63:0] cols_0_to_7;
    logic [15:0] cols_8_to_9;
    logic        rx_error;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    logic [79:0]  model_keys;
    logic         model_rp;
    logic [81:0]  exp_q[$];
    string        name_q[$];

    ps2_bbc_keyboard #(.timeout_cycles(TIMEOUT), .dip_switches(8'h81)) dut (
        .clk                                 (clk),
        .reset_n                             (reset_n),
        .ps2_clk                             (ps2_clk),
        .ps2_data                            (ps2_data),
        .bbc_keyboard__reset_pressed         (reset_pressed),
        .bbc_keyboard__keys_down_cols_0_to_7 (cols_0_to_7),
        .bbc_keyboard__keys_down_cols_8_to_9 (cols_8_to_9),
        .rx_error                            (rx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got keys=%h break=%b err=%b, required keys=%h break=%b err=%b",
                     name, act[81:2], act[1], act[0], exp[81:2], exp[1], exp[0]);
        end
    endtask

    task automatic expect_event(input string name, input logic err);
        exp_q.push_back({model_keys, model_rp, err});
        name_q.push_back(name);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_parity = 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_parity);
        ps2_bit(1'b1);
    endtask

    // Monitor: any Break/matrix change or rx_error pulse is one DUT event.
    initial begin
        logic [81:0] prev;
        logic [81:0] snap;
        wait (reset_n === 1'b1);
        @(negedge clk);
        prev = {cols_8_to_9, cols_0_to_7, reset_pressed, 1'b0};
        while (!done) begin
            @(negedge clk);
            snap = {cols_8_to_9, cols_0_to_7, reset_pressed, rx_error};
            if (snap[0] !== 1'b0 || snap[81:1] !== prev[81:1]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got keys=%h break=%b err=%b, required no change from keys=%h break=%b",
                             snap[81:2], snap[1], snap[0], prev[81:2], prev[1]);
                end else begin
                    check(name_q.pop_front(), snap, exp_q.pop_front());
                end
            end
            prev = snap;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        model_keys = DIP_MODEL;
        model_rp   = 1'b0;

        repeat (3) @(negedge clk);
        check("in_reset", {cols_8_to_9, cols_0_to_7, reset_pressed, rx_error}, {DIP_MODEL, 2'b00});
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset", {cols_8_to_9, cols_0_to_7, reset_pressed, rx_error}, {DIP_MODEL, 2'b00});

        model_keys[12] = 1'b1; expect_event("press_A", 1'b0);
        send(8'h1C);
        model_keys[12] = 1'b0; expect_event("release_A", 1'b0);
        send(8'hF0); send(8'h1C);

        model_keys[79] = 1'b1; expect_event("press_right", 1'b0);
        send(8'hE0); send(8'h74);
        model_keys[79] = 1'b0; expect_event("release_right", 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        model_keys[35] = 1'b1; expect_event("press_kp6", 1'b0);
        send(8'h74);
        model_keys[35] = 1'b0; expect_event("release_kp6", 1'b0);
        send(8'hF0); send(8'h74);

        expect_event("parity_error", 1'b1);
        send(8'h76, 1'b1);
        model_keys[7] = 1'b1; expect_event("press_esc", 1'b0);
        send(8'h76);
        model_keys[7] = 1'b0; expect_event("release_esc", 1'b0);
        send(8'hF0); send(8'h76);

        expect_event("timeout", 1'b1);
        partial = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(partial[i]);
        repeat (TIMEOUT + 100) @(negedge clk);
        model_keys[12] = 1'b1; expect_event("press_A_after_timeout", 1'b0);
        send(8'h1C);

        model_keys[0] = 1'b1; expect_event("press_lshift", 1'b0);
        send(8'h12);
        model_rp = 1'b1; expect_event("break_press", 1'b0);
        send(8'h07);
        model_rp = 1'b0; expect_event("break_release", 1'b0);
        send(8'hF0); send(8'h07);
        model_rp = 1'b1; expect_event("break_hold", 1'b0);
        send(8'h07);
        model_keys = DIP_MODEL; model_rp = 1'b0; expect_event("bat_clear", 1'b0);
        send(8'hAA);

        model_keys[0] = 1'b1; expect_event("press_rshift", 1'b0);
        send(8'h59);
        model_keys[0] = 1'b0; expect_event("release_lshift_alias", 1'b0);
        send(8'hF0); send(8'h12);
        model_keys[8] = 1'b1; expect_event("press_rctrl", 1'b0);
        send(8'hE0); send(8'h14);
        model_keys[8] = 1'b0; expect_event("release_lctrl_alias", 1'b0);
        send(8'hF0); send(8'h14);

        send(8'hFA);
        model_keys[12] = 1'b1; expect_event("press_A_after_ack", 1'b0);
        send(8'h1C);
        send(8'hE0); send(8'h12);
        send(8'hF0); send(8'h00);
        model_keys[12] = 1'b0; expect_event("release_after_consumed_prefix", 1'b0);
        send(8'hF0); send(8'h1C);

        model_keys[12] = 1'b1; expect_event("press_A_before_zero", 1'b0);
        send(8'h1C);
        model_keys = DIP_MODEL; expect_event("zero_clear", 1'b0);
        send(8'h00);
        model_keys[7] = 1'b1; expect_event("press_esc_before_ff", 1'b0);
        send(8'h76);
        model_keys = DIP_MODEL; expect_event("overrun_clear", 1'b0);
        send(8'hFF);

        repeat (50) @(negedge clk);
        done = 1'b1;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_event %s: got no event, required keys=%h break=%b err=%b",
                     name_q[0], exp_q[0][81:2], exp_q[0][1], exp_q[0][0]);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        check("final_state", {cols_8_to_9, cols_0_to_7, reset_pressed, rx_error}, {model_keys, model_rp, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
